// File: rtl/adder_op_sequencer.sv
// adder_op_sequencer: pops {mode, a, b} operand words from a synchronous-read
// FIFO, drives them onto an external add/sub adder, registers {carry, sum}
// and offers the result on a valid/ready handshake. One operation in flight.
// Optional feature macro: ADDER_SEQ_CNT_EN enables the op_count register;
// without it op_count is tied to zero.
module adder_op_sequencer #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                fifo_empty,
    input  logic [2*DATA_W:0]   fifo_rdata,
    output logic                fifo_rd_en,
    output logic [DATA_W-1:0]   add_a,
    output logic [DATA_W-1:0]   add_b,
    output logic                add_mode,
    input  logic [DATA_W-1:0]   add_sum,
    input  logic                add_carry,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [DATA_W:0]     res_data,
    output logic                res_mode,
    output logic                busy,
    output logic [CNT_W-1:0]    op_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   rd_en_c;
    logic   handshake;

    assign handshake = (state_q == HOLD) && res_valid && res_ready;
    assign busy      = (state_q != IDLE);

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and pop-request decode.
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        rd_en_c = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    rd_en_c = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: state_d = EXEC;
            EXEC:  state_d = HOLD;
            HOLD: begin
                if (handshake) begin
                    if (!fifo_empty) begin
                        rd_en_c = 1'b1;
                        state_d = FETCH;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The pop request is combinational, so reset must mask it explicitly:
    // the IDLE decode alone would still pop a non-empty FIFO during reset.
    assign fifo_rd_en = rd_en_c & rst_n;

    // Operand registers: loaded from the FIFO read data in FETCH and held
    // afterwards so the adder inputs stay stable through HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            add_a    <= '0;
            add_b    <= '0;
            add_mode <= 1'b0;
        end else if (state_q == FETCH) begin
            add_mode <= fifo_rdata[2*DATA_W];
            add_a    <= fifo_rdata[2*DATA_W-1:DATA_W];
            add_b    <= fifo_rdata[DATA_W-1:0];
        end
    end

    // Result register: capture the settled adder output in EXEC, hold it
    // through HOLD, drop valid on the consumer handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_mode  <= 1'b0;
        end else if (state_q == EXEC) begin
            res_valid <= 1'b1;
            res_data  <= {add_carry, add_sum};
            res_mode  <= add_mode;
        end else if (handshake) begin
            res_valid <= 1'b0;
        end
    end

`ifdef ADDER_SEQ_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Completed-result counter; wraps naturally at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (handshake) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign op_count = cnt_q;
`else
    assign op_count = '0;
`endif

endmodule
